// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key scanner types, constants and helpers
package key_pkg;

    localparam int NKEYS = 11;

    typedef logic [3:0] key_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } scan_state_t;

    // Bit 0 is the highest note, bit 10 the lowest.
    localparam int KEY_B  = 0;
    localparam int KEY_AS = 1;
    localparam int KEY_A  = 2;
    localparam int KEY_GS = 3;
    localparam int KEY_G  = 4;
    localparam int KEY_FS = 5;
    localparam int KEY_F  = 6;
    localparam int KEY_E  = 7;
    localparam int KEY_DS = 8;
    localparam int KEY_D  = 9;
    localparam int KEY_CS = 10;

    function automatic key_idx_t lowest_set(input logic [NKEYS-1:0] v);
        key_idx_t r;
        r = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = key_idx_t'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [NKEYS-1:0] key_onehot(input key_idx_t idx);
        logic [NKEYS-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser and stability counter for one key line
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DB_W            = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic [DB_W-1:0] cnt;

    // cnt only advances while s2 disagrees with deb and clears on the flip, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_scanner.sv
// rtl/key_scanner.sv - debounced monophonic key arbiter; KEYSCAN_LATCH_EN holds the last note after release
module key_scanner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DB_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] keys_raw,
    output logic [NKEYS-1:0] keys,
    output logic [3:0]       key_idx,
    output logic             note_on,
    output logic             press_pulse,
    output logic             release_pulse
);

    logic [NKEYS-1:0] deb;

    for (genvar g = 0; g < NKEYS; g++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_W           (DB_W)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (keys_raw[g]),
            .deb  (deb[g])
        );
    end

    scan_state_t      state, state_d;
    key_idx_t         sel, sel_d;
    logic [NKEYS-1:0] keys_d;
    key_idx_t         idx_d;
    logic             press_d;
    logic             release_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sel           <= '0;
            keys          <= '0;
            key_idx       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_d;
            sel           <= sel_d;
            keys          <= keys_d;
            key_idx       <= idx_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    always_comb begin
        state_d   = state;
        sel_d     = sel;
        keys_d    = keys;
        idx_d     = key_idx;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state)
            IDLE: begin
                if (|deb) begin
                    sel_d   = lowest_set(deb);
                    keys_d  = key_onehot(sel_d);
                    idx_d   = sel_d;
                    press_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Presses of other keys are ignored until the held one is dropped.
                if (!deb[sel]) begin
                    release_d = 1'b1;
                    if (|deb) begin
                        sel_d   = lowest_set(deb);
                        keys_d  = key_onehot(sel_d);
                        idx_d   = sel_d;
                        press_d = 1'b1;
                    end else begin
                        state_d = IDLE;
`ifdef KEYSCAN_LATCH_EN
                        keys_d  = keys;
                        idx_d   = key_idx;
`else
                        keys_d  = '0;
                        idx_d   = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign note_on = |keys;

endmodule

// File: tb/tb_key_scanner.sv
// tb/tb_key_scanner.sv - directed and randomized checks of key_scanner against a reference model
module tb_key_scanner;

    localparam int DC = 4;
    localparam int NK = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] keys_raw = '0;
    logic [NK-1:0] keys;
    logic [3:0]    key_idx;
    logic          note_on;
    logic          press_pulse;
    logic          release_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_scanner #(
        .DEBOUNCE_CYCLES(DC),
        .DB_W           (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .keys_raw     (keys_raw),
        .keys         (keys),
        .key_idx      (key_idx),
        .note_on      (note_on),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

`ifdef KEYSCAN_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    function automatic int tb_lowest(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Reference model: raw sample history, note held flag, selected index.
    logic [NK-1:0] hist[$];
    logic [NK-1:0] m_deb;
    logic [NK-1:0] m_keys;
    int            m_sel;
    bit            m_hold;
    bit            m_press;
    bit            m_rel;

    task automatic model_reset();
        hist.delete();
        repeat (DC + 2) hist.push_back('0);
        m_deb   = '0;
        m_keys  = '0;
        m_sel   = 0;
        m_hold  = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
    endtask

    task automatic model_edge(input logic [NK-1:0] r);
        bit all_differ;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (!m_hold) begin
            if (m_deb != 0) begin
                m_sel   = tb_lowest(m_deb);
                m_keys  = '0;
                m_keys[m_sel] = 1'b1;
                m_press = 1'b1;
                m_hold  = 1'b1;
            end
        end else if (!m_deb[m_sel]) begin
            m_rel = 1'b1;
            if (m_deb != 0) begin
                m_sel   = tb_lowest(m_deb);
                m_keys  = '0;
                m_keys[m_sel] = 1'b1;
                m_press = 1'b1;
            end else begin
                m_hold = 1'b0;
                if (!LATCH) m_keys = '0;
            end
        end
        // A key flips once its last DC synchronised samples all disagree with it.
        hist.push_back(r);
        for (int i = 0; i < NK; i++) begin
            all_differ = 1'b1;
            for (int k = 0; k < DC; k++) begin
                if (hist[hist.size() - 3 - k][i] == m_deb[i]) all_differ = 1'b0;
            end
            if (all_differ) m_deb[i] = ~m_deb[i];
        end
        while (hist.size() > DC + 2) void'(hist.pop_front());
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        keys_raw = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_pulse(input bit want_press, input int limit, output int found);
        found = -1;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk);
            #1;
            if (want_press ? press_pulse : release_pulse) begin
                found = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n    = 1'b0;
        keys_raw = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({keys, key_idx, note_on, press_pulse, release_pulse} !== '0) begin
            errors++;
            $display("FAIL reset_state: keys=%h idx=%0d on=%b p=%b r=%b, required all 0",
                     keys, key_idx, note_on, press_pulse, release_pulse);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (keys !== '0 || note_on !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_clean_press();
        int found;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        keys_raw = 11'h004;
        wait_pulse(1'b1, 20, found);
        checks++;
        if (found != DC + 2 || keys !== 11'h004 || key_idx !== 4'd2 || note_on !== 1'b1) begin
            errors++;
            $display("FAIL clean_press: edge=%0d keys=%h idx=%0d on=%b, required edge=%0d keys=004 idx=2 on=1",
                     found, keys, key_idx, note_on, DC + 2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL press_width: press_pulse=%b, required 0", press_pulse);
        end
        keys_raw = '0;
        wait_pulse(1'b0, 20, found);
        checks++;
        if (found != DC + 2 || keys !== (LATCH ? 11'h004 : 11'h000) || press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clean_release: edge=%0d keys=%h p=%b, required edge=%0d keys=%h p=0",
                     found, keys, press_pulse, DC + 2, LATCH ? 11'h004 : 11'h000);
        end
    endtask

    task automatic test_bounce();
        int bad;
        int found;
        do_reset();
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            keys_raw = ((c % 5) < 3) ? 11'h001 : 11'h000;
            @(posedge clk);
            #1;
            if (keys !== '0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_reject: %0d active cycles, required 0", bad);
        end
        keys_raw = 11'h001;
        wait_pulse(1'b1, 20, found);
        checks++;
        if (found < 0 || keys !== 11'h001 || key_idx !== 4'd0) begin
            errors++;
            $display("FAIL bounce_settle: edge=%0d keys=%h idx=%0d, required keys=001 idx=0", found, keys, key_idx);
        end
    endtask

    task automatic test_priority();
        int found;
        int bad;
        do_reset();
        keys_raw = 11'h110;
        wait_pulse(1'b1, 20, found);
        checks++;
        if (found < 0 || keys !== 11'h010 || key_idx !== 4'd4) begin
            errors++;
            $display("FAIL priority_simul: keys=%h idx=%0d, required keys=010 idx=4", keys, key_idx);
        end
        keys_raw = 11'h111;
        bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (keys !== 11'h010 || press_pulse !== 1'b0 || release_pulse !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_no_steal: %0d disturbed cycles, required 0", bad);
        end
        keys_raw = 11'h101;
        wait_pulse(1'b0, 20, found);
        checks++;
        if (found < 0 || press_pulse !== 1'b1 || keys !== 11'h001 || key_idx !== 4'd0) begin
            errors++;
            $display("FAIL handover: edge=%0d p=%b keys=%h idx=%0d, required p=1 keys=001 idx=0",
                     found, press_pulse, keys, key_idx);
        end
        keys_raw = '0;
        wait_pulse(1'b0, 20, found);
        checks++;
        if (found < 0 || press_pulse !== 1'b0 || keys !== (LATCH ? 11'h001 : 11'h000)) begin
            errors++;
            $display("FAIL release_all: edge=%0d p=%b keys=%h, required p=0 keys=%h",
                     found, press_pulse, keys, LATCH ? 11'h001 : 11'h000);
        end
    endtask

    task automatic test_async_reset();
        int found;
        int bad;
        do_reset();
        keys_raw = 11'h040;
        wait_pulse(1'b1, 20, found);
        checks++;
        if (found < 0 || keys !== 11'h040 || key_idx !== 4'd6) begin
            errors++;
            $display("FAIL async_press: keys=%h idx=%0d, required keys=040 idx=6", keys, key_idx);
        end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (keys !== '0 || key_idx !== '0 || note_on !== 1'b0) begin
            errors++;
            $display("FAIL async_drop: keys=%h idx=%0d on=%b, required 0", keys, key_idx, note_on);
        end
        keys_raw = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (keys !== '0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL async_quiet: %0d active cycles after reset, required 0", bad);
        end
    endtask

    task automatic test_latch();
        int found;
        do_reset();
        keys_raw = 11'h200;
        wait_pulse(1'b1, 20, found);
        checks++;
        if (found != DC + 2 || keys !== 11'h200 || key_idx !== 4'd9) begin
            errors++;
            $display("FAIL latch_press: edge=%0d keys=%h idx=%0d, required edge=%0d keys=200 idx=9",
                     found, keys, key_idx, DC + 2);
        end
        keys_raw = '0;
        wait_pulse(1'b0, 20, found);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (found != DC + 2 || keys !== (LATCH ? 11'h200 : 11'h000) || note_on !== LATCH) begin
            errors++;
            $display("FAIL latch_release: edge=%0d keys=%h on=%b, required edge=%0d keys=%h on=%b",
                     found, keys, note_on, DC + 2, LATCH ? 11'h200 : 11'h000, LATCH);
        end
        keys_raw = 11'h002;
        wait_pulse(1'b1, 20, found);
        checks++;
        if (found != DC + 2 || keys !== 11'h002 || key_idx !== 4'd1 || release_pulse !== 1'b0) begin
            errors++;
            $display("FAIL latch_replace: edge=%0d keys=%h idx=%0d r=%b, required keys=002 idx=1 r=0",
                     found, keys, key_idx, release_pulse);
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] pattern;
        logic [NK-1:0] r;
        int            seg;
        logic [3:0]    exp_idx;
        do_reset();
        model_reset();
        pattern = '0;
        seg     = 0;
        for (int c = 0; c < 800; c++) begin
            if (seg == 0) begin
                seg     = $urandom_range(1, 12);
                pattern = NK'($urandom & $urandom & $urandom);
            end
            seg--;
            r = pattern;
            if ($urandom_range(0, 15) == 0) r[$urandom_range(0, NK - 1)] ^= 1'b1;
            keys_raw = r;
            @(posedge clk);
            model_edge(r);
            #1;
            exp_idx = 4'(tb_lowest(m_keys));
            checks++;
            if (keys !== m_keys || key_idx !== exp_idx || note_on !== (|m_keys)
                || press_pulse !== m_press || release_pulse !== m_rel) begin
                errors++;
                $display("FAIL random c=%0d: keys=%h idx=%0d on=%b p=%b r=%b, required keys=%h idx=%0d on=%b p=%b r=%b",
                         c, keys, key_idx, note_on, press_pulse, release_pulse,
                         m_keys, exp_idx, |m_keys, m_press, m_rel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_priority();
        test_async_reset();
        test_latch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_scanner.md
Name: key_scanner

Overview:
- Front-end stage directly upstream of the synthesiser.
- Takes 11 raw mechanical key lines (asynchronous, bouncy) and synchronises and debounces each one.
- Arbitrates them to a strictly one-hot (or zero) 11-bit `keys` word, which is the only encoding the synthesiser's note decoder accepts.
- Emits single-cycle press/release event pulses for the record path.

Parameters:
- NKEYS, 11, number of key lines; bit 0 = highest note (B), bit 10 = lowest (C#).
- DEBOUNCE_CYCLES, 1000, consecutive stable synchronised samples required before a key's debounced state flips; legal range 1..2^DB_W-1.
- DB_W, 16, width of each per-key debounce counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- keys_raw, input, NKEYS, raw key levels, 1 = pressed, asynchronous to clk.
- keys, output, NKEYS, registered one-hot selected key, or 0 when no key is held.
- key_idx, output, 4, binary index of the selected key; 0 when keys==0.
- note_on, output, 1, equals |keys.
- press_pulse, output, 1, one-cycle pulse when a new key becomes selected.
- release_pulse, output, 1, one-cycle pulse when the selected key is dropped.

Behaviour:
- Reset: rst_n low asynchronously clears all of the following. Outputs hold 0 until the first debounced press.
  - sync flops
  - debounced states
  - counters
  - FSM (to IDLE)
  - keys, key_idx, note_on, press_pulse, release_pulse
- Synchroniser: two flops per bit (s1, s2).
- Debounce, per key:
  - deb[i] is the debounced state; cnt[i] is its counter.
  - When s2[i]==deb[i], cnt[i] clears to 0.
  - Otherwise cnt[i] increments.
  - On the edge where cnt[i]==DEBOUNCE_CYCLES-1 and s2[i]!=deb[i]: deb[i] takes s2[i] and cnt[i] clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes deb.
  - cnt saturates by construction and never wraps.
- Latency: a raw edge sampled at clock edge N reaches `keys` at edge N+DEBOUNCE_CYCLES+2. The same latency applies to release.
- Arbitration FSM, states IDLE and HOLD, with register sel[3:0]:
  - IDLE, deb==0: stay; keys=0.
  - IDLE, deb!=0: sel = lowest set index of deb; keys = 1<<sel; press_pulse=1; go to HOLD.
  - HOLD, deb[sel]==1: stay. Newly pressed keys are ignored (no retrigger, no steal).
  - HOLD, deb[sel]==0 and other deb bits set: release_pulse=1 and press_pulse=1 in the same cycle; sel = lowest remaining set index; stay in HOLD.
  - HOLD, deb==0: release_pulse=1; keys=0; key_idx=0; go to IDLE.
- Simultaneous presses debounced on the same edge: lowest index wins.
- Pulses are registered, exactly one cycle wide, and never asserted during or on the cycle following reset release unless a debounced transition occurred.
- Reset mid-hold: outputs drop to 0 immediately. No release_pulse is generated.

Optional Feature:
- Macro: KEYSCAN_LATCH_EN.
- Defined:
  - "Latch" mode: when the selected key is released with no other key held, keys and key_idx keep the last note and note_on stays 1; release_pulse still fires.
  - The latched note is replaced only by a new debounced press, which fires press_pulse.
  - Keys returns to 0 only on reset.
- Undefined: behaviour exactly as above, i.e. keys=0 on last release.

Decomposition:
- Shared package key_pkg:
  - NKEYS
  - the key-index type (4-bit)
  - FSM state enum (IDLE, HOLD)
  - a lowest-set-bit function returning an index
  - named constants for key bit positions
- Sub-module key_debounce: one bit of synchroniser plus counter, parameterised by DEBOUNCE_CYCLES and DB_W, instantiated NKEYS times. Arbitration FSM and output registers live in key_scanner.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset then idle: rst_n low 3 cycles, keys_raw=0 for 20 cycles -> keys=0, note_on=0, no pulses.
- Clean press: keys_raw=11'h004 held -> keys=11'h004, key_idx=2 and a press_pulse exactly 6 edges after first sampling; release -> keys=0 and release_pulse 6 edges later.
- Bounce rejection: keys_raw[0] toggled with 3-cycle-high/2-cycle-low pattern for 30 cycles -> keys stays 0, no pulses; then held high -> keys=11'h001.
- Priority and hold:
  - Press 11'h010 and 11'h100 simultaneously -> keys=11'h010.
  - Then press bit 0 -> keys unchanged.
  - Release bit 4 -> same-cycle release_pulse and press_pulse, keys=11'h001.
- Async reset mid-hold: keys=11'h040, rst_n pulsed low mid-cycle -> keys=0 immediately, no release_pulse after reset release.
- KEYSCAN_LATCH_EN build: press and release 11'h200 -> keys stays 11'h200, note_on=1, release_pulse seen; press 11'h002 -> keys=11'h002 with press_pulse.
